// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole scheduler: state encoding,
// default hole count and the per-level mole visibility times in milliseconds.
package mole_pkg;

  localparam int NUM_HOLES_DEF = 8;
  localparam int UP_W          = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    UP
  } state_t;

  function automatic logic [UP_W-1:0] up_time(input logic [1:0] lvl);
    case (lvl)
      2'd0:    up_time = 10'd1000;
      2'd1:    up_time = 10'd750;
      2'd2:    up_time = 10'd500;
      default: up_time = 10'd300;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter8.sv
// 8-bit event counter that increments on enable and sticks at 255.
module sat_counter8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: waits a random number of ms, lights one hole for a
// level-dependent time, and scores hits, misses and early presses.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int NUM_HOLES = NUM_HOLES_DEF,
  parameter int CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           level,
  input  logic [CNT_W-1:0]     random_value,
  input  logic                 tick_ms,
  input  logic [NUM_HOLES-1:0] hit,
  output logic [NUM_HOLES-1:0] mole_on,
  output logic                 hit_ok,
  output logic                 miss,
  output logic                 early,
  output logic [7:0]           hit_count,
  output logic [7:0]           miss_count
);

  localparam int POS_W = $clog2(NUM_HOLES);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     delay_cnt, delay_nxt;
  logic [UP_W-1:0]      up_cnt, up_nxt;
  logic [POS_W-1:0]     pos, pos_nxt;
  logic [NUM_HOLES-1:0] mole_nxt;
  logic                 hit_ok_nxt, miss_nxt, early_nxt;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    delay_nxt  = delay_cnt;
    up_nxt     = up_cnt;
    pos_nxt    = pos;
    mole_nxt   = '0;
    hit_ok_nxt = 1'b0;
    miss_nxt   = 1'b0;
    early_nxt  = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = LOAD;
        LOAD: begin
          early_nxt = |hit;
          delay_nxt = (random_value == '0) ? CNT_W'(1) : random_value;
          state_nxt = WAIT;
        end
        WAIT: begin
          early_nxt = |hit;
          if (tick_ms) begin
            if (delay_cnt == CNT_W'(1)) begin
              // Hole and level are captured at the spawn tick, not at LOAD.
              pos_nxt   = random_value[POS_W-1:0];
              up_nxt    = up_time(level);
              mole_nxt  = NUM_HOLES'(1) << random_value[POS_W-1:0];
              state_nxt = UP;
            end else begin
              delay_nxt = delay_cnt - CNT_W'(1);
            end
          end
        end
        UP: begin
          if (hit[pos]) begin
            hit_ok_nxt = 1'b1;
            state_nxt  = LOAD;
          end else if (tick_ms && (up_cnt == UP_W'(1))) begin
            miss_nxt  = 1'b1;
            state_nxt = LOAD;
          end else begin
            mole_nxt = NUM_HOLES'(1) << pos;
            if (tick_ms) up_nxt = up_cnt - UP_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      delay_cnt <= '0;
      up_cnt    <= '0;
      pos       <= '0;
      mole_on   <= '0;
      hit_ok    <= 1'b0;
      miss      <= 1'b0;
      early     <= 1'b0;
    end else begin
      state     <= state_nxt;
      delay_cnt <= delay_nxt;
      up_cnt    <= up_nxt;
      pos       <= pos_nxt;
      mole_on   <= mole_nxt;
      hit_ok    <= hit_ok_nxt;
      miss      <= miss_nxt;
      early     <= early_nxt;
    end
  end

  sat_counter8 u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_ok_nxt),
    .count (hit_count)
  );

  sat_counter8 u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_nxt),
    .count (miss_count)
  );

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: a phase-level game model predicts the
// outputs after every edge; a monitor compares them against the DUT.
module tb_mole_scheduler;

  localparam int NH = 8;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    level = 2'd0;
  logic [CW-1:0] random_value = '0;
  logic          tick_ms = 1'b1;
  logic [NH-1:0] hit = '0;
  logic [NH-1:0] mole_on;
  logic          hit_ok, miss, early;
  logic [7:0]    hit_count, miss_count;

  mole_scheduler #(.NUM_HOLES(NH), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .level        (level),
    .random_value (random_value),
    .tick_ms      (tick_ms),
    .hit          (hit),
    .mole_on      (mole_on),
    .hit_ok       (hit_ok),
    .miss         (miss),
    .early        (early),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NH-1:0] mole;
    logic          hit_ok;
    logic          miss;
    logic          early;
    logic [7:0]    hc;
    logic [7:0]    mc;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Game model: counts ticks up towards goals rather than down.
  typedef enum int {PH_IDLE, PH_LOAD, PH_WAIT, PH_UP} phase_e;
  phase_e ph;
  int     wait_goal, wait_seen, up_goal, up_seen, hole, hits, misses;
  int     up_ms[4] = '{1000, 750, 500, 300};

  function automatic void model_reset();
    ph = PH_IDLE; hole = 0; hits = 0; misses = 0;
    wait_goal = 0; wait_seen = 0; up_goal = 0; up_seen = 0;
  endfunction

  // Predict the outcome of the coming edge from current inputs, then clock.
  task automatic step();
    obs_t e;
    e = '0;
    if (!enable) begin
      ph = PH_IDLE;
    end else begin
      case (ph)
        PH_IDLE: ph = PH_LOAD;
        PH_LOAD: begin
          e.early   = |hit;
          wait_goal = (random_value == 0) ? 1 : int'(random_value);
          wait_seen = 0;
          ph        = PH_WAIT;
        end
        PH_WAIT: begin
          e.early = |hit;
          if (tick_ms) begin
            wait_seen++;
            if (wait_seen >= wait_goal) begin
              hole    = int'(random_value) % NH;
              up_goal = up_ms[level];
              up_seen = 0;
              ph      = PH_UP;
            end
          end
        end
        PH_UP: begin
          if (hit[hole]) begin
            e.hit_ok = 1'b1;
            if (hits < 255) hits++;
            ph = PH_LOAD;
          end else if (tick_ms) begin
            up_seen++;
            if (up_seen >= up_goal) begin
              e.miss = 1'b1;
              if (misses < 255) misses++;
              ph = PH_LOAD;
            end
          end
        end
        default: ph = PH_IDLE;
      endcase
    end
    if (ph == PH_UP) e.mole[hole] = 1'b1;
    e.hc = hits[7:0];
    e.mc = misses[7:0];
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_up();
    for (int g = 0; g < 5000 && ph != PH_UP; g++) step();
  endtask

  initial begin : monitor
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {mole_on, hit_ok, miss, early, hit_count, miss_count};
        check("outputs", 64'(got), 64'(e));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit did_reset = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", 64'({mole_on, hit_ok, miss, early, hit_count, miss_count}), 64'(0));
    rst_n = 1'b1;

    // Spawn delay of 5 ticks into hole 5.
    enable = 1'b1; level = 2'd3; random_value = 11'd5;
    step(); step();
    repeat (4) step();
    check("spawn_not_yet", 64'(mole_on), 64'(0));
    step();
    check("spawn_delay", 64'(mole_on), 64'(8'b0010_0000));

    // Level-3 timeout after 300 UP cycles.
    repeat (299) step();
    check("miss_not_yet", 64'(miss), 64'(0));
    step();
    check("miss_pulse", 64'(miss), 64'(1));
    check("miss_count", 64'(miss_count), 64'(1));
    check("mole_off_after_miss", 64'(mole_on), 64'(0));
    step();
    check("miss_one_cycle", 64'(miss), 64'(0));

    // Press in WAIT is early only.
    hit = 8'b0000_0100; step(); hit = '0;
    check("early_pulse", 64'({early, hit_ok}), 64'(2'b10));

    // Wrong hole ignored, correct hole at UP cycle 10 scores.
    run_to_up();
    step();
    hit = 8'b0000_0100; step(); hit = '0;
    check("wrong_hit_ignored", 64'({mole_on, hit_ok, early}), 64'({8'b0010_0000, 2'b00}));
    repeat (7) step();
    hit = 8'b0010_0000; step(); hit = '0;
    check("hit_ok_pulse", 64'(hit_ok), 64'(1));
    check("hit_count", 64'(hit_count), 64'(1));
    check("mole_off_after_hit", 64'(mole_on), 64'(0));

    // Hit on the timeout tick wins.
    run_to_up();
    for (int g = 0; g < 2000 && up_seen < up_goal - 1; g++) step();
    hit = '0; hit[hole] = 1'b1; step(); hit = '0;
    check("simul_hit_wins", 64'({hit_ok, miss}), 64'(2'b10));
    check("simul_miss_count", 64'(miss_count), 64'(1));

    // Saturation of hit_count.
    random_value = 11'd1; level = 2'd0;
    for (int r = 0; r < 260; r++) begin
      run_to_up();
      hit = '0; hit[hole] = 1'b1; step(); hit = '0;
    end
    check("hit_saturate", 64'(hit_count), 64'(255));

    // Disable mid-UP: IDLE next cycle, counts held, no pulses.
    run_to_up();
    enable = 1'b0; step();
    check("disable_mole_off", 64'(mole_on), 64'(0));
    hit = 8'hFF; step(); hit = '0;
    check("disable_no_pulse", 64'({hit_ok, miss, early}), 64'(0));
    check("disable_counts_held", 64'({hit_count, miss_count}), 64'({8'd255, 8'd1}));

    // Randomized play with one asynchronous reset while a mole is up.
    for (int i = 0; i < 4000; i++) begin
      enable       = ($urandom_range(0, 99) < 97);
      level        = 2'($urandom_range(0, 3));
      random_value = CW'($urandom_range(0, 12));
      tick_ms      = 1'($urandom_range(0, 1));
      hit          = '0;
      if (ph != PH_IDLE) begin
        int r = $urandom_range(0, 99);
        if (r < 4 && ph == PH_UP) hit[hole] = 1'b1;
        else if (r < 8) hit[$urandom_range(0, NH - 1)] = 1'b1;
      end
      if (!did_reset && i > 2000 && ph == PH_UP && enable) begin
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'({mole_on, hit_ok, miss, early, hit_count, miss_count}), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        did_reset = 1;
      end
      step();
    end
    hit = '0; enable = 1'b0;
    step();
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_HOLES, default 8, number of mole holes (power of two, ≤16).
REQ-002 The module SHALL have parameter CNT_W, default 11, width of random_value and delay counter.
REQ-003 The module SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 The module SHALL have port enable  input  1  game running; low forces IDLE.
REQ-006 The module SHALL have port level  input  2  difficulty 0..3.
REQ-007 The module SHALL have port random_value  input  CNT_W  random delay in ms from rng_mole; low log2(NUM_HOLES) bits also select the hole.
REQ-008 The module SHALL have port tick_ms  input  1  one-cycle 1 ms strobe.
REQ-009 The module SHALL have port hit  input  NUM_HOLES  debounced, one-cycle button pulses, one bit per hole.
REQ-010 The module SHALL have port mole_on  output  NUM_HOLES  one-hot lit mole, or all zero.
REQ-011 The module SHALL have port hit_ok  output  1  one-cycle pulse on a correct hit.
REQ-012 The module SHALL have port miss  output  1  one-cycle pulse on mole timeout.
REQ-013 The module SHALL have port early  output  1  one-cycle pulse on any hit while no mole is shown.
REQ-014 The module SHALL have ports hit_count and miss_count  output  8  saturating totals.

Function
REQ-015 The state machine SHALL use four states: IDLE, LOAD, WAIT, UP.
REQ-016 IDLE SHALL go to LOAD on the first cycle with enable=1.
REQ-017 LOAD SHALL last one cycle and set delay_cnt to random_value (0 loads as 1), then go to WAIT.
REQ-018 WAIT SHALL decrement delay_cnt on each tick_ms.
REQ-019 A tick_ms while delay_cnt==1 SHALL latch pos=random_value[log2(NUM_HOLES)-1:0] and set up_cnt=UP_TIME[level]; the next state is UP.
REQ-020 In UP, mole_on SHALL be the one-hot encoding of pos, registered, starting the first UP cycle.
REQ-021 In UP, up_cnt SHALL decrement on each tick_ms.
REQ-022 In UP, hit[pos]=1 SHALL pulse hit_ok, increment hit_count and go to LOAD.
REQ-023 In UP, other hit bits SHALL be ignored.
REQ-024 In UP, a tick_ms while up_cnt==1 with no hit[pos] SHALL pulse miss, increment miss_count and go to LOAD.
REQ-025 If hit[pos] and timeout occur in the same cycle, hit SHALL win: hit_ok only, no miss.
REQ-026 In WAIT or LOAD, any hit bit set SHALL pulse early; the state and counters are unchanged.
REQ-027 level SHALL be sampled only at WAIT->UP; level changes during UP have no effect.
REQ-028 enable=0 in any state SHALL give IDLE on the next edge, with mole_on=0 and no pulses.
REQ-029 hit_count and miss_count SHALL hold while enable=0; they clear only on reset.
REQ-030 Counters SHALL saturate at 255 with no wrap.
REQ-031 Pulse outputs SHALL be registered: asserted exactly one cycle, in the cycle after the triggering edge.
REQ-032 Latency SHALL be: WAIT entry to mole_on = random_value ticks; hit edge to mole_on=0 = 1 cycle.

Reset
REQ-033 rst_n low SHALL asynchronously set state=IDLE, mole_on=0, hit_ok=miss=early=0, hit_count=miss_count=0, delay_cnt=up_cnt=0 and pos=0.
REQ-034 Reset deassertion mid-game SHALL resume from IDLE; a mole shown before reset is not restored.

Structure
REQ-035 Shared package mole_pkg SHALL hold the state enum, NUM_HOLES default and UP_TIME table: L0=1000, L1=750, L2=500, L3=300 ms.
REQ-036 Counter widths SHALL be CNT_W for delay_cnt and 10 bits for up_cnt.
REQ-037 Sub-module sat_counter8 (increment enable, saturate at 255) SHALL be instantiated twice, for hit_count and miss_count.
REQ-038 Everything else SHALL be inline in mole_scheduler.

Verification (tick_ms tied high unless stated)
REQ-039 Reset check: assert rst_n=0 mid-UP -> all outputs 0 immediately, without a clock edge.
REQ-040 Spawn delay: enable=1, random_value=5 -> mole_on=8'b0010_0000 exactly 5 cycles after WAIT entry.
REQ-041 Timeout: level=3, no hit -> miss pulses after 300 UP cycles; miss_count=1; mole_on=0 next cycle.
REQ-042 Hit versus wrong or early: hit[5] at UP cycle 10 -> hit_ok and hit_count=1; hit[2] in UP -> ignored; hit[2] in WAIT -> early only.
REQ-043 Simultaneous hit and timeout: hit[pos] on the timeout tick -> hit_ok=1, miss=0, miss_count unchanged.
REQ-044 Saturation and enable: 260 correct hits -> hit_count=255; enable=0 during UP -> IDLE next cycle, counts held.
